// File: rtl/apb_master_multi.sv
// APB master driving NUM_SLAVES completers: address decode to one-hot PSEL,
// back-to-back transfers, wait-state timeout and decode-error responses.
//
// Ports:
//   PCLK, PRESET                      clock, synchronous active-high reset
//   start_transfer, addr, wr, wdata   request side (captured at acceptance)
//   busy, done, rdata, slverr, timeout completion side (done is a pulse)
//   PADDR, PSEL, PENABLE, PWRITE,
//   PWDATA, PREADY, PSLVERR, PRDATA   APB bus, per-slave return signals
// Optional macro APB_MASTER_APB4_EN adds wstrb/prot inputs and PSTRB/PPROT.
module apb_master_multi #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SLV_ADDR_LSB   = 28,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic                             start_transfer,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic                             wr,
  input  logic [DATA_WIDTH-1:0]            wdata,
`ifdef APB_MASTER_APB4_EN
  input  logic [DATA_WIDTH/8-1:0]          wstrb,
  input  logic [2:0]                       prot,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  output logic [2:0]                       PPROT,
`endif
  output logic                             busy,
  output logic                             done,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             slverr,
  output logic                             timeout,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA
);

  localparam int SEL_BITS =
    (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [SEL_BITS-1:0]   r_idx;
  logic                  r_derr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_done;
  logic                  r_slverr;
  logic                  r_tmo;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic [SEL_BITS-1:0]   w_idx;
  logic [NUM_SLAVES-1:0] w_hit;
  logic                  w_rdy;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_prd;
  logic                  w_tmo_hit;
  logic                  w_accept;
  logic                  w_fin_ok;
  logic                  w_fin_to;
  logic                  w_cnt_inc;
  logic [NUM_SLAVES-1:0] w_psel;
  logic                  w_penable;
  logic                  w_busy;

  assign w_idx = addr[SLV_ADDR_LSB +: SEL_BITS];

  // Return-path mux: only the captured slave index contributes.
  always_comb begin
    w_hit = '0;
    w_rdy = 1'b0;
    w_err = 1'b0;
    w_prd = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_hit[i] = (32'(r_idx) == i);
      w_rdy    = w_rdy | (PREADY[i] & w_hit[i]);
      w_err    = w_err | (PSLVERR[i] & w_hit[i]);
      w_prd    = w_prd |
        (PRDATA[i*DATA_WIDTH +: DATA_WIDTH] &
         {DATA_WIDTH{w_hit[i]}});
    end
  end

  // Counter holds the number of wait cycles already spent;
  // reaching TIMEOUT_CYCLES-1 means this is the last allowed one.
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) &&
    (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_psel    = '0;
    w_penable = 1'b0;
    w_busy    = 1'b0;
    w_accept  = 1'b0;
    w_fin_ok  = 1'b0;
    w_fin_to  = 1'b0;
    w_cnt_inc = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_transfer) begin
          w_accept = 1'b1;
          w_next   = SETUP;
        end
      end
      SETUP: begin
        w_busy = 1'b1;
        w_psel = r_derr ? '0 : w_hit;
        w_next = ACCESS;
      end
      ACCESS: begin
        w_busy    = 1'b1;
        w_psel    = r_derr ? '0 : w_hit;
        w_penable = ~r_derr;
        if (r_derr || w_rdy) w_fin_ok  = 1'b1;
        else if (w_tmo_hit)  w_fin_to  = 1'b1;
        else                 w_cnt_inc = 1'b1;
        if (w_fin_ok || w_fin_to) begin
          w_accept = start_transfer;
          w_next   = start_transfer ? SETUP : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_addr   <= '0;
      r_wr     <= 1'b0;
      r_wdata  <= '0;
      r_idx    <= '0;
      r_derr   <= 1'b0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_slverr <= 1'b0;
      r_tmo    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_done   <= w_fin_ok | w_fin_to;
      r_tmo    <= w_fin_to;
      r_slverr <= w_fin_to | (w_fin_ok & (r_derr | w_err));
      if (w_fin_ok && !r_derr && !r_wr) r_rdata <= w_prd;
      if (w_accept) begin
        r_addr  <= addr;
        r_wr    <= wr;
        r_wdata <= wdata;
        r_idx   <= w_idx;
        r_derr  <= (32'(w_idx) >= NUM_SLAVES);
      end
      if (r_state == SETUP) r_cnt <= '0;
      else if (w_cnt_inc)   r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef APB_MASTER_APB4_EN
  logic [DATA_WIDTH/8-1:0] r_strb;
  logic [2:0]              r_prot;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_strb <= '0;
      r_prot <= '0;
    end else if (w_accept) begin
      r_strb <= wstrb;
      r_prot <= prot;
    end
  end

  assign PSTRB = (w_busy && r_wr && !r_derr) ? r_strb : '0;
  assign PPROT = r_prot;
`endif

  assign busy    = w_busy;
  assign done    = r_done;
  assign rdata   = r_rdata;
  assign slverr  = r_slverr;
  assign timeout = r_tmo;
  assign PADDR   = r_addr;
  assign PSEL    = w_psel;
  assign PENABLE = w_penable;
  assign PWRITE  = r_wr;
  assign PWDATA  = r_wdata;

endmodule

// File: tb/tb_apb_master_multi.sv
// Testbench for apb_master_multi: transaction-level model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_apb_master_multi;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int N   = 4;
  localparam int LSB = 28;
  localparam int TO  = 16;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          st    = 1'b0;
  logic          wr    = 1'b0;
  logic [AW-1:0] addr  = '0;
  logic [DW-1:0] wdata = '0;

  logic          busy, done, slverr, tmo, pen, pwrite;
  logic [DW-1:0] rdata, pwdata;
  logic [AW-1:0] paddr;
  logic [N-1:0]  psel;
  logic [N-1:0]  pready;
  logic [N-1:0]  pslverr = '0;
  logic [N*DW-1:0] prdata;

  logic          busy3, done3, slverr3, tmo3, pen3, pwrite3;
  logic [DW-1:0] rdata3, pwdata3;
  logic [AW-1:0] paddr3;
  logic [2:0]    psel3;
  logic [2:0]    pready3;
  logic [2:0]    pslverr3;
  logic [3*DW-1:0] prdata3;

  int lat[N];
  int acc[N];
  logic noise = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  apb_master_multi #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(N),
    .SLV_ADDR_LSB(LSB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(clk), .PRESET(rst), .start_transfer(st),
    .addr(addr), .wr(wr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata),
    .slverr(slverr), .timeout(tmo),
    .PADDR(paddr), .PSEL(psel), .PENABLE(pen),
    .PWRITE(pwrite), .PWDATA(pwdata),
    .PREADY(pready), .PSLVERR(pslverr), .PRDATA(prdata)
  );

  assign pready3  = 3'b111;
  assign pslverr3 = pslverr[2:0];
  assign prdata3  = prdata[3*DW-1:0];

  apb_master_multi #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(3),
    .SLV_ADDR_LSB(LSB), .TIMEOUT_CYCLES(TO)
  ) dut3 (
    .PCLK(clk), .PRESET(rst), .start_transfer(st),
    .addr(addr), .wr(wr), .wdata(wdata),
    .busy(busy3), .done(done3), .rdata(rdata3),
    .slverr(slverr3), .timeout(tmo3),
    .PADDR(paddr3), .PSEL(psel3), .PENABLE(pen3),
    .PWRITE(pwrite3), .PWDATA(pwdata3),
    .PREADY(pready3), .PSLVERR(pslverr3), .PRDATA(prdata3)
  );

  // Bench slaves: slave i answers after lat[i] wait cycles.
  // With noise set, unselected slaves show PREADY high.
  always @(posedge clk)
    for (int i = 0; i < N; i++)
      acc[i] <= (psel[i] && pen && !pready[i]) ? acc[i] + 1 : 0;

  always_comb begin
    pready = '0;
    for (int i = 0; i < N; i++)
      pready[i] = (psel[i] && pen) ? (acc[i] >= lat[i]) : noise;
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: age counts cycles since acceptance
  // (1 = setup phase, >=2 = access phase).
  logic          m_on = 1'b0;
  logic          m_act = 1'b0, m_err = 1'b0, m_wr = 1'b0;
  int            m_age = 0, m_waits = 0, m_idx = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0, m_rd = '0;
  logic          m_done = 1'b0, m_slv = 1'b0, m_to = 1'b0;

  always @(negedge clk) begin : model
    logic fin, finto;
    logic [N-1:0] esel;
    if (m_on) begin
      esel = '0;
      if (m_act && !m_err) esel = 4'b0001 << m_idx;
      chk("busy", busy, m_act);
      chk("psel", psel, esel);
      chk("penable", pen, m_act && m_age >= 2 && !m_err);
      chk("done", done, m_done);
      chk("slverr", slverr, m_slv);
      chk("timeout", tmo, m_to);
      chk("rdata", rdata, m_rd);
      if (m_act) begin
        chk("paddr", paddr, m_addr);
        chk("pwrite", pwrite, m_wr);
        chk("pwdata", pwdata, m_wd);
      end
    end
    if (rst) begin
      m_on = 1'b1; m_act = 1'b0;
      m_done = 1'b0; m_slv = 1'b0; m_to = 1'b0; m_rd = '0;
    end else begin
      fin = 1'b0; finto = 1'b0;
      if (m_act && m_age >= 2) begin
        if (m_err || pready[m_idx]) fin = 1'b1;
        else if (TO > 0 && m_waits + 1 >= TO) begin
          fin = 1'b1; finto = 1'b1;
        end
      end
      m_done = fin;
      m_to   = finto;
      m_slv  = fin && (m_err || finto || pslverr[m_idx]);
      if (fin && !m_err && !finto && !m_wr)
        m_rd = prdata[m_idx*DW +: DW];
      if (st && (!m_act || fin)) begin
        m_act = 1'b1; m_age = 1; m_waits = 0;
        m_addr = addr; m_wr = wr; m_wd = wdata;
        m_idx = int'(addr[LSB +: 2]);
        m_err = (m_idx >= N);
      end else if (fin) begin
        m_act = 1'b0;
      end else if (m_act) begin
        if (m_age >= 2) m_waits++;
        m_age++;
      end
    end
  end

  task automatic xfer(input logic [31:0] a, input logic w,
                      input logic [31:0] d, input int maxc,
                      output int n, output int nsel,
                      output int npen, output logic [N-1:0] sel);
    @(posedge clk); #1;
    st = 1'b1; addr = a; wr = w; wdata = d;
    n = 0; nsel = 0; npen = 0; sel = '0;
    do begin
      @(posedge clk);
      n++;
      if (n == 1) begin #1 st = 1'b0; end
      @(negedge clk);
      if (psel != 0) begin nsel++; sel = psel; end
      if (pen) npen++;
    end while (!done && n < maxc);
    if (!done) begin
      tests++; fails++;
      $display("FAIL xfer_bound: no done after %0d cycles", n);
    end
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, ns, np;
    logic [N-1:0] sel;
    for (int i = 0; i < N; i++) lat[i] = 0;
    prdata = {32'h3333_3333, 32'h2222_2222,
              32'h1111_1111, 32'h0BAD_0000};

    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_psel", psel, 0);
    chk("rst_pen", pen, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rdata", rdata, 0);

    xfer(32'h1000_0040, 1'b1, 32'hDEAD_BEEF, 40, n, ns, np, sel);
    chk("wr_lat", n, 3);
    chk("wr_selcyc", ns, 2);
    chk("wr_pencyc", np, 1);
    chk("wr_sel", sel, 4'b0010);
    chk("wr_slverr", slverr, 0);

    @(posedge clk); #1;
    lat[2] = 3; noise = 1'b1; pslverr = 4'b1011;
    prdata[2*DW +: DW] = 32'h1234_5678;
    xfer(32'h2000_0000, 1'b0, 32'h0, 40, n, ns, np, sel);
    chk("rd_lat", n, 6);
    chk("rd_pencyc", np, 4);
    chk("rd_data", rdata, 32'h1234_5678);
    chk("rd_slverr", slverr, 0);

    @(posedge clk); #1;
    lat[2] = 0; noise = 1'b0; pslverr = '0;
    prdata[2*DW +: DW] = 32'h2222_2222;
    lat[0] = 1000;
    xfer(32'h0000_0100, 1'b1, 32'h5555_AAAA, 60, n, ns, np, sel);
    chk("to_lat", n, 18);
    chk("to_pencyc", np, 16);
    chk("to_slverr", slverr, 1);
    chk("to_flag", tmo, 1);
    chk("to_psel", psel, 0);
    chk("to_busy", busy, 0);

    @(posedge clk); #1;
    lat[0] = 0; pslverr = 4'b0010;
    @(posedge clk); #1;
    st = 1'b1; addr = 32'h1000_0008; wr = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    addr = 32'h3000_0010; wr = 1'b0;
    @(negedge clk);
    chk("b2b_sel1", psel, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_acc1", {psel, pen}, {4'b0010, 1'b1});
    @(posedge clk); #1 st = 1'b0;
    @(negedge clk);
    chk("b2b_done1", {done, slverr}, 2'b11);
    chk("b2b_sel2", {psel, pen, busy}, {4'b1000, 1'b0, 1'b1});
    @(posedge clk);
    @(negedge clk);
    chk("b2b_acc2", {psel, pen}, {4'b1000, 1'b1});
    @(posedge clk);
    @(negedge clk);
    chk("b2b_done2", {done, slverr}, 2'b10);
    chk("b2b_rdata", rdata, 32'h3333_3333);
    chk("b2b_idle", psel, 0);

    @(posedge clk); #1;
    pslverr = '0;
    @(posedge clk); #1;
    st = 1'b1; addr = 32'h3000_0000; wr = 1'b1; wdata = 32'h0000_00C3;
    @(posedge clk); #1 st = 1'b0;
    @(negedge clk);
    chk("dec_setup", {psel3, pen3, busy3}, {3'b000, 1'b0, 1'b1});
    @(posedge clk);
    @(negedge clk);
    chk("dec_access", {psel3, pen3, done3}, {3'b000, 1'b0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    chk("dec_done", {done3, slverr3, tmo3}, 3'b110);
    chk("dec_idle", busy3, 0);
    chk("dec_ok4", {done, slverr}, 2'b10);

    @(posedge clk); #1;
    lat[2] = 1000;
    st = 1'b1; addr = 32'h2000_0004; wr = 1'b0;
    @(posedge clk); #1 st = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mrst_bus", {psel, pen, busy, done}, 7'b0);
    @(negedge clk);
    chk("mrst_nodone", done, 0);
    @(posedge clk); #1;
    lat[2] = 0;
    xfer(32'h2000_0004, 1'b0, 32'h0, 40, n, ns, np, sel);
    chk("mrst_lat", n, 3);
    chk("mrst_rdata", rdata, 32'h2222_2222);

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
